// File: rtl/stream_insertion_sorter.sv
// rtl/stream_insertion_sorter.sv - streaming insertion sorter: load one frame of keys, drain sorted (SORTER_DESCEND_EN selects largest-first)
module stream_insertion_sorter #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 7,
    localparam int CNTW = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_last,
    output logic [CNTW-1:0]  frame_len
);

    localparam logic [0:0] LOAD  = 1'b0;
    localparam logic [0:0] DRAIN = 1'b1;

    logic [0:0]       r_state;
    logic [CNTW-1:0]  r_cnt;
    logic [CNTW-1:0]  r_frame_len;
    logic [WIDTH-1:0] r_key [DEPTH];

    logic             w_ge    [DEPTH];
    logic [WIDTH-1:0] w_ins   [DEPTH];
    logic [WIDTH-1:0] w_shift [DEPTH];
    logic             w_accept;
    logic             w_pop;
    logic             w_close;

    assign in_ready  = (r_state == LOAD);
    assign out_valid = (r_state == DRAIN);
    assign out_data  = r_key[0];
    assign out_last  = (r_state == DRAIN) && (r_cnt == CNTW'(1));
    assign frame_len = r_frame_len;

    assign w_accept = in_valid && (r_state == LOAD);
    assign w_pop    = out_ready && (r_state == DRAIN);
    assign w_close  = in_last || (r_cnt == CNTW'(DEPTH - 1));

    // Mark every slot at or above the insert point; strict compare keeps equal keys in arrival order
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            w_ge[i] = 1'b0;
            if (CNTW'(i) < r_cnt) begin
`ifdef SORTER_DESCEND_EN
                w_ge[i] = (in_data > r_key[i]);
`else
                w_ge[i] = (in_data < r_key[i]);
`endif
            end else begin
                w_ge[i] = (CNTW'(i) == r_cnt);
            end
        end
    end

    // Next array contents for an insert: new key at the first marked slot, marked slots above it shift up
    always_comb begin
        w_ins[0] = w_ge[0] ? in_data : r_key[0];
        for (int i = 1; i < DEPTH; i++) begin
            if (!w_ge[i])
                w_ins[i] = r_key[i];
            else if (w_ge[i-1])
                w_ins[i] = r_key[i-1];
            else
                w_ins[i] = in_data;
        end
    end

    // Next array contents for a pop: everything moves one slot toward the head
    always_comb begin
        for (int i = 0; i < DEPTH - 1; i++)
            w_shift[i] = r_key[i+1];
        w_shift[DEPTH-1] = '0;
    end

    // State, occupancy, frame length and key storage
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= LOAD;
            r_cnt       <= '0;
            r_frame_len <= '0;
            for (int i = 0; i < DEPTH; i++)
                r_key[i] <= '0;
        end else if (w_accept) begin
            for (int i = 0; i < DEPTH; i++)
                r_key[i] <= w_ins[i];
            r_cnt <= r_cnt + CNTW'(1);
            if (w_close) begin
                r_state     <= DRAIN;
                r_frame_len <= r_cnt + CNTW'(1);
            end
        end else if (w_pop) begin
            for (int i = 0; i < DEPTH; i++)
                r_key[i] <= w_shift[i];
            r_cnt <= r_cnt - CNTW'(1);
            if (r_cnt == CNTW'(1)) begin
                r_state     <= LOAD;
                r_frame_len <= '0;
            end
        end
    end

endmodule

// File: tb/tb_stream_insertion_sorter.sv
// tb/tb_stream_insertion_sorter.sv - directed self-checking bench for stream_insertion_sorter (SORTER_DESCEND_EN aware)
module tb_stream_insertion_sorter;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       in_last;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic       out_last;
    logic [2:0] frame_len;

    int checks   = 0;
    int failures = 0;

    stream_insertion_sorter #(.WIDTH(8), .DEPTH(7)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .frame_len (frame_len)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic push(input int d, input logic l);
        int n = 0;
        in_valid = 1'b1;
        in_data  = 8'(d);
        in_last  = l;
        while (!in_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (!in_ready) check("push_timeout", 0, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic pop(input string tag, input int exp, input logic exp_last);
        out_ready = 1'b1;
        check({tag, "_valid"}, int'(out_valid), 1);
        check({tag, "_data"}, int'(out_data), exp);
        check({tag, "_last"}, int'(out_last), int'(exp_last));
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    int in1[7] = '{5, 3, 9, 1, 7, 2, 8};
`ifdef SORTER_DESCEND_EN
    int ex1[7] = '{9, 8, 7, 5, 3, 2, 1};
    int ex2[3] = '{200, 6, 4};
    int ex3[3] = '{4, 4, 2};
    int ex4[2] = '{30, 20};
    int ex4b[2] = '{255, 0};
    int ex5[2] = '{50, 40};
`else
    int ex1[7] = '{1, 2, 3, 5, 7, 8, 9};
    int ex2[3] = '{4, 6, 200};
    int ex3[3] = '{2, 4, 4};
    int ex4[2] = '{10, 20};
    int ex4b[2] = '{0, 255};
    int ex5[2] = '{40, 50};
`endif
    logic pat3[5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        check("rst_in_ready", int'(in_ready), 1);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_out_data", int'(out_data), 0);
        check("rst_frame_len", int'(frame_len), 0);
        rst = 1'b0;

        // 1: seven keys, no in_last, auto-close at DEPTH
        for (int i = 0; i < 7; i++) push(in1[i], 1'b0);
        check("t1_frame_len", int'(frame_len), 7);
        check("t1_in_ready", int'(in_ready), 0);
        for (int i = 0; i < 7; i++) pop("t1", ex1[i], i == 6);
        check("t1_back_load", int'(in_ready), 1);
        check("t1_len_zero", int'(frame_len), 0);
        check("t1_ov_zero", int'(out_valid), 0);

        // 2: explicit in_last
        push(6, 1'b0); push(4, 1'b0); push(200, 1'b1);
        check("t2_frame_len", int'(frame_len), 3);
        for (int i = 0; i < 3; i++) pop("t2", ex2[i], i == 2);
        check("t2_in_ready", int'(in_ready), 1);

        // 3: duplicates with out_ready backpressure 1,0,0,1,1
        begin
            int idx = 0;
            push(4, 1'b0); push(4, 1'b0); push(2, 1'b1);
            for (int c = 0; c < 5; c++) begin
                out_ready = pat3[c];
                check("t3_valid", int'(out_valid), 1);
                check("t3_data", int'(out_data), ex3[idx]);
                check("t3_last", int'(out_last), int'(idx == 2));
                @(posedge clk); #1;
                if (pat3[c]) idx++;
            end
            out_ready = 1'b0;
            check("t3_count", idx, 3);
            check("t3_done", int'(out_valid), 0);
        end

        // 4: reset in the middle of a drain
        push(10, 1'b0); push(30, 1'b0); push(20, 1'b1);
        for (int i = 0; i < 2; i++) pop("t4", ex4[i], 1'b0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("t4_out_valid", int'(out_valid), 0);
        check("t4_in_ready", int'(in_ready), 1);
        check("t4_out_data", int'(out_data), 0);
        check("t4_out_last", int'(out_last), 0);
        check("t4_frame_len", int'(frame_len), 0);
        push(0, 1'b0); push(255, 1'b1);
        check("t4b_frame_len", int'(frame_len), 2);
        for (int i = 0; i < 2; i++) pop("t4b", ex4b[i], i == 1);

        // 5: in_valid held through DRAIN is not taken until LOAD
        push(50, 1'b0); push(40, 1'b1);
        in_valid = 1'b1; in_data = 8'd77; in_last = 1'b1;
        check("t5_in_ready", int'(in_ready), 0);
        for (int i = 0; i < 2; i++) pop("t5", ex5[i], i == 1);
        check("t5_load_ready", int'(in_ready), 1);
        check("t5_load_ov", int'(out_valid), 0);
        @(posedge clk); #1;
        in_valid = 1'b0; in_last = 1'b0;
        check("t5_frame_len", int'(frame_len), 1);
        pop("t5b", 77, 1'b1);
        check("t5_end_ready", int'(in_ready), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
